// File: rtl/flash_cmd_master.sv
// flash_cmd_master: turns byte program/read requests into nibble-encoded flash programmer commands.
// Optional address cache: define FLASH_CMD_ADDR_CACHE_EN to skip address nibbles already sent.
module flash_cmd_master #(
    parameter int POLL_MAX = 1023
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [22:0] i_addr,
    input  logic [7:0]  i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [7:0]  o_rdata,
    output logic        o_timeout,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_stb,
    input  logic        i_tx_ready,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_rdy,
    output logic        o_rx_ack
);
    typedef enum logic [2:0] {IDLE, SEND, GAP, WAIT_RSP, DONE} state_t;

    state_t      state, state_nx;
    logic [3:0]  step;
    logic        wr_q;
    logic [22:0] addr_q;
    logic [7:0]  wdata_q;
    logic [15:0] poll_cnt;
    logic [3:0]  nib;
    logic [7:0]  cur_byte;
    logic        is_addr, is_rsp, skip, accept, adv, last_poll;

    // Steps 0-5 are address nibbles; the rest depend on the operation type.
    assign nib       = 4'({1'b0, addr_q} >> {step, 2'b00});
    assign is_addr   = step < 4'd6;
    assign cur_byte  = is_addr ? {step, nib} :
                       wr_q ? (step == 4'd6  ? {4'h6, wdata_q[3:0]} :
                               step == 4'd7  ? {4'h7, wdata_q[7:4]} :
                               step == 4'd8  ? 8'h85 :
                               step == 4'd9  ? 8'h87 :
                               step == 4'd10 ? 8'h8F : 8'hA0) :
                              (step == 4'd6  ? 8'h83 :
                               step == 4'd7  ? 8'h90 : 8'h8F);
    assign is_rsp    = cur_byte == 8'h90 || cur_byte == 8'hA0;
    assign accept    = (state == IDLE || state == DONE) && i_req;
    assign adv       = (state == SEND && skip) || (state == GAP && !is_rsp);
    assign last_poll = poll_cnt == 16'(POLL_MAX);

`ifdef FLASH_CMD_ADDR_CACHE_EN
    logic [22:0] cache_addr;
    logic        cache_vld;

    assign skip = is_addr && cache_vld && 4'({1'b0, cache_addr} >> {step, 2'b00}) == nib;

    // Remember the address once its last nibble has been sent or skipped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cache_addr <= '0;
            cache_vld  <= 1'b0;
        end else if (adv && step == 4'd5) begin
            cache_addr <= addr_q;
            cache_vld  <= 1'b1;
        end
    end
`else
    assign skip = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: state_nx = i_req ? SEND : IDLE;
            SEND:       state_nx = skip ? SEND : i_tx_ready ? GAP : SEND;
            GAP:        state_nx = is_rsp ? WAIT_RSP : (!wr_q && step == 4'd8) ? DONE : SEND;
            WAIT_RSP:   state_nx = !i_rx_rdy ? WAIT_RSP :
                                   (cur_byte == 8'hA0 && (i_rx_data[0] || last_poll)) ? DONE : SEND;
            default:    state_nx = IDLE;
        endcase
    end

    // Outputs; every received byte is acked, but only WAIT_RSP consumes it.
    always_comb begin
        o_busy    = state == SEND || state == GAP || state == WAIT_RSP;
        o_done    = state == DONE;
        o_tx_stb  = state == SEND && !skip && i_tx_ready;
        o_tx_data = o_tx_stb ? cur_byte : 8'h00;
        o_rx_ack  = i_rx_rdy && i_rst_n;
    end

    // Request capture, step/poll sequencing and result registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            step      <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            poll_cnt  <= '0;
            o_rdata   <= '0;
            o_timeout <= 1'b0;
        end else begin
            if (accept) begin
                wr_q      <= i_wr;
                addr_q    <= i_addr;
                wdata_q   <= i_wdata;
                step      <= '0;
                poll_cnt  <= '0;
                o_timeout <= 1'b0;
            end
            if (adv) step <= step + 4'd1;
            if (o_tx_stb && cur_byte == 8'hA0) poll_cnt <= poll_cnt + 16'd1;
            if (state == WAIT_RSP && i_rx_rdy) begin
                if (cur_byte == 8'h90) begin
                    o_rdata <= i_rx_data;
                    step    <= step + 4'd1;
                end else if (!i_rx_data[0] && last_poll) begin
                    o_timeout <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_flash_cmd_master.sv
// tb_flash_cmd_master: directed and randomized checks of flash_cmd_master against a byte-list model
module tb_flash_cmd_master;
  localparam int PM = 4;
`ifdef FLASH_CMD_ADDR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  logic        clk = 0, rst_n = 0, req = 0, wr = 0;
  logic [22:0] addr = 0;
  logic [7:0]  wdata = 0;
  logic        busy, done, timeout, tx_stb, rx_ack;
  logic [7:0]  rdata, tx_data;
  logic        tx_ready = 1, rx_rdy = 0;
  logic [7:0]  rx_data = 0;
  int          checks = 0, errors = 0;
  bit          tx_hold = 0, tx_rand = 0;
  logic [7:0]  got_q[$], exp_q[$], rsp_q[$];
  int          acks = 0, cyc = 0, last_stb = -10;
  bit          ref_cvld = 0;
  logic [22:0] ref_caddr = 0;
  logic        exp_to;
  logic [7:0]  exp_rd;
  int          exp_acks;
  bit          exp_read;
  flash_cmd_master #(.POLL_MAX(PM)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wr(wr), .i_addr(addr), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_rdata(rdata), .o_timeout(timeout),
    .o_tx_data(tx_data), .o_tx_stb(tx_stb), .i_tx_ready(tx_ready),
    .i_rx_data(rx_data), .i_rx_rdy(rx_rdy), .o_rx_ack(rx_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #2 tx_ready = tx_hold ? 1'b0 : tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  initial forever begin
    @(negedge clk);
    cyc++;
    if (tx_stb) begin
      chk("stb_ready", tx_ready, 1'b1);
      chk("stb_spacing", cyc - last_stb >= 2, 1'b1);
      last_stb = cyc;
      got_q.push_back(tx_data);
    end
    if (rx_ack) acks++;
  end
  initial forever begin
    @(negedge clk);
    if (tx_stb && (tx_data == 8'h90 || tx_data == 8'hA0)) begin
      repeat ($urandom_range(2, 4)) @(posedge clk);
      #2;
      if (rsp_q.size() > 0) rx_data = rsp_q.pop_front();
      else rx_data = 8'h01;
      rx_rdy = 1;
      @(posedge clk);
      #1 rx_rdy = 0;
    end
  end
  task automatic build_exp(input bit w, input logic [22:0] a, input logic [7:0] d, input int kz, input logic [7:0] rd);
    logic [3:0] n, c;
    int polls;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      n = 4'({1'b0, a} >> (4 * i));
      c = 4'({1'b0, ref_caddr} >> (4 * i));
      if (!(CACHE && ref_cvld && c == n)) exp_q.push_back({4'(i), n});
    end
    if (CACHE) begin
      ref_cvld  = 1;
      ref_caddr = a;
    end
    exp_read = !w;
    if (w) begin
      exp_q.push_back({4'h6, d[3:0]});
      exp_q.push_back({4'h7, d[7:4]});
      exp_q.push_back(8'h85);
      exp_q.push_back(8'h87);
      exp_q.push_back(8'h8F);
      polls = (kz < PM) ? kz + 1 : PM;
      repeat (polls) exp_q.push_back(8'hA0);
      exp_to   = kz >= PM;
      exp_acks = polls;
    end else begin
      exp_q.push_back(8'h83);
      exp_q.push_back(8'h90);
      exp_q.push_back(8'h8F);
      exp_rd   = rd;
      exp_to   = 0;
      exp_acks = 1;
    end
  endtask
  task automatic start_op(input bit w, input logic [22:0] a, input logic [7:0] d, input int kz, input logic [7:0] rd);
    rsp_q.delete();
    if (w) begin
      repeat (kz) rsp_q.push_back(8'($urandom) & 8'hFE);
      rsp_q.push_back(8'($urandom) | 8'h01);
    end else rsp_q.push_back(rd);
    build_exp(w, a, d, kz, rd);
    @(negedge clk);
    got_q.delete();
    acks = 0;
    req = 1; wr = w; addr = a; wdata = d;
    @(negedge clk);
    req = 0; wr = 1'($urandom); addr = 23'($urandom); wdata = 8'($urandom);
    chk("busy_after_accept", busy, 1'b1);
  endtask
  task automatic finish_op();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 3000);
    chk("done_seen", done, 1'b1);
    chk("busy_at_done", busy, 1'b0);
    chk("timeout", timeout, exp_to);
    if (exp_read) chk("rdata", rdata, exp_rd);
    chk("acks", acks, exp_acks);
    chk("nbytes", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk("byte", got_q[i], exp_q[i]);
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
  endtask
  task automatic do_op(input bit w, input logic [22:0] a, input logic [7:0] d, input int kz, input logic [7:0] rd);
    start_op(w, a, d, kz, rd);
    finish_op();
  endtask
  task automatic check_reset_outputs();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_stb", tx_stb, 1'b0);
    chk("rst_txdata", tx_data, 8'h00);
    chk("rst_ack", rx_ack, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_timeout", timeout, 1'b0);
  endtask
  initial begin
    logic [22:0] prev;
    int sz0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1;
    do_op(1, 23'h123456, 8'h5A, 0, 8'h00);
    do_op(0, 23'h7ABCDE, 8'h00, 0, 8'hC3);
    do_op(1, 23'h0F00F0, 8'h3C, 5, 8'h00);
    start_op(1, 23'($urandom), 8'($urandom), 2, 8'h00);
    repeat (4) @(negedge clk);
    tx_hold = 1;
    @(negedge clk);
    req = 1; wr = 0; addr = 23'h555555;
    @(negedge clk);
    req = 0;
    sz0 = got_q.size();
    repeat (20) @(negedge clk);
    chk("stall_no_bytes", got_q.size(), sz0);
    tx_hold = 0;
    finish_op();
    tx_rand = 1;
    prev = 23'($urandom);
    for (int i = 0; i < 10; i++) begin
      prev = (i % 3 == 2) ? prev + 23'd1 : 23'($urandom);
      do_op(1'($urandom_range(0, 1)), prev, 8'($urandom), $urandom_range(0, 5), 8'($urandom));
    end
    tx_rand = 0;
    do_op(1, 23'h000100, 8'h11, 0, 8'h00);
    do_op(1, 23'h000101, 8'h22, 1, 8'h00);
    do_op(0, 23'h000200, 8'h00, 0, 8'hA5);
    start_op(1, 23'h000300, 8'h77, 0, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1 check_reset_outputs();
    ref_cvld = 0;
    @(negedge clk);
    rst_n = 1;
    do_op(0, 23'h000000, 8'h00, 0, 8'h3E);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
